// File: rtl/sinc3_seq.sv
// Channel sequencer for a shared sinc3 decimator: selects, resets, settles and captures one word per enabled channel.
// Optional settle/capture watchdog with sticky timeout_err is enabled by defining SINC3_SEQ_TIMEOUT_EN.
module sinc3_seq #(
    parameter int NCH          = 4,
    parameter int CHW          = 2,
    parameter int SETTLE_WORDS = 2,
    parameter int RST_CYCLES   = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic           mclk1,
    input  logic           reset_n,
    input  logic           start,
    input  logic           stop,
    input  logic           continuous,
    input  logic [NCH-1:0] chan_mask,
    input  logic           word_clk,
    input  logic [15:0]    filt_data,
    output logic [CHW-1:0] chan_sel,
    output logic           filt_reset,
    output logic [15:0]    out_data,
    output logic [CHW-1:0] out_chan,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           overrun
`ifdef SINC3_SEQ_TIMEOUT_EN
    ,
    output logic           timeout_err
`endif
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS + 1) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_N = SW'(SETTLE_WORDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        NEXT    = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic           cont_q, cont_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic           frst_q, frst_d;
    logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
    logic           wc_q;
    logic [15:0]    out_data_q, out_data_d;
    logic [CHW-1:0] out_chan_q, out_chan_d;
    logic           out_valid_q, out_valid_d;
    logic           overrun_q, overrun_d;
    logic           wc_edge;

`ifdef SINC3_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           tmo_q, tmo_d;
`endif

    // Lowest set bit of the start mask, lowest set bit of the latched mask, next set bit above chan_q.
    logic [CHW-1:0] lo_in_ch, lo_q_ch, nxt_ch;
    logic           nxt_found;

    always_comb begin
        lo_in_ch  = '0;
        lo_q_ch   = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) lo_in_ch = CHW'(i);
            if (mask_q[i]) lo_q_ch = CHW'(i);
            if (mask_q[i] && (i > int'(chan_q))) begin
                nxt_ch    = CHW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    assign wc_edge = word_clk & ~wc_q;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cont_d       = cont_q;
        chan_d       = chan_q;
        frst_d       = 1'b0;
        rst_cnt_d    = rst_cnt_q;
        settle_cnt_d = settle_cnt_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        out_valid_d  = out_valid_q & ~out_ready;
        overrun_d    = overrun_q;
`ifdef SINC3_SEQ_TIMEOUT_EN
        wd_d         = wd_q;
        tmo_d        = tmo_q;
`endif
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (|chan_mask)) begin
                        mask_d    = chan_mask;
                        cont_d    = continuous;
                        chan_d    = lo_in_ch;
                        overrun_d = 1'b0;
                        frst_d    = 1'b1;
                        rst_cnt_d = '0;
                        state_d   = FLUSH;
`ifdef SINC3_SEQ_TIMEOUT_EN
                        tmo_d     = 1'b0;
`endif
                    end
                end
                FLUSH: begin
                    if (rst_cnt_q == RST_LAST) begin
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
                    end else begin
                        frst_d    = 1'b1;
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (SETTLE_WORDS == 0) begin
                        state_d = CAPTURE;
                    end else if (wc_edge) begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                        if (settle_cnt_d == SETTLE_N) state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (wc_edge) begin
                        // A word still waiting for acceptance wins; the new one is dropped.
                        if (!out_valid_q || out_ready) begin
                            out_data_d  = filt_data;
                            out_chan_d  = chan_q;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (nxt_found) begin
                        chan_d    = nxt_ch;
                        frst_d    = 1'b1;
                        rst_cnt_d = '0;
                        state_d   = FLUSH;
                    end else if (cont_q) begin
                        chan_d    = lo_q_ch;
                        frst_d    = 1'b1;
                        rst_cnt_d = '0;
                        state_d   = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
`ifdef SINC3_SEQ_TIMEOUT_EN
            if (state_q == FLUSH) begin
                wd_d = '0;
            end else if ((state_q == SETTLE) || (state_q == CAPTURE)) begin
                if (wc_edge || (state_d != state_q)) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge mclk1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            cont_q       <= 1'b0;
            chan_q       <= '0;
            frst_q       <= 1'b0;
            rst_cnt_q    <= '0;
            settle_cnt_q <= '0;
            wc_q         <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SINC3_SEQ_TIMEOUT_EN
            wd_q         <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cont_q       <= cont_d;
            chan_q       <= chan_d;
            frst_q       <= frst_d;
            rst_cnt_q    <= rst_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            wc_q         <= word_clk;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
`ifdef SINC3_SEQ_TIMEOUT_EN
            wd_q         <= wd_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign chan_sel   = chan_q;
    assign filt_reset = frst_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
`ifdef SINC3_SEQ_TIMEOUT_EN
    assign timeout_err = tmo_q;
`endif

endmodule

// File: tb/tb_sinc3_seq.sv
// Bench for sinc3_seq: behavioural sinc3 word-clock model, randomized masks/data, scoreboard of accepted words.
module tb_sinc3_seq;

    localparam int NCH = 4, CHW = 2, SETTLE_WORDS = 2, RST_CYCLES = 4, TIMEOUT = 1024;
    localparam int WPER = 256;
    localparam int SCAN_BUDGET = NCH * 1000 + 400;

    logic           mclk1, reset_n, start, stop, continuous, word_clk, out_ready;
    logic [NCH-1:0] chan_mask;
    logic [15:0]    filt_data, out_data;
    logic [CHW-1:0] chan_sel, out_chan;
    logic           filt_reset, out_valid, busy, overrun;
`ifdef SINC3_SEQ_TIMEOUT_EN
    logic           timeout_err;
`endif

    sinc3_seq #(.NCH(NCH), .CHW(CHW), .SETTLE_WORDS(SETTLE_WORDS),
                .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .mclk1(mclk1), .reset_n(reset_n), .start(start), .stop(stop),
        .continuous(continuous), .chan_mask(chan_mask), .word_clk(word_clk),
        .filt_data(filt_data), .chan_sel(chan_sel), .filt_reset(filt_reset),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun)
`ifdef SINC3_SEQ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    initial mclk1 = 1'b0;
    always #5 mclk1 = ~mclk1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Filter model: word edge 128 cycles after reset release, then every 256; first SETTLE_WORDS words are junk.
    int          fcnt, fedges;
    logic        wc_hold;
    logic [15:0] fbase;
    always @(negedge mclk1) begin
        if (filt_reset || !reset_n) begin
            fcnt = 0; fedges = 0; word_clk = 1'b0;
        end else begin
            fcnt++;
            word_clk = !wc_hold && ((fcnt % WPER) >= WPER / 2);
            if (!wc_hold && (fcnt % WPER) == WPER / 2) begin
                filt_data = (fedges >= SETTLE_WORDS) ? fbase + 16'(chan_sel) : 16'hBAD0 + 16'(fedges);
                fedges++;
            end
        end
    end

    typedef struct { logic [CHW-1:0] ch; logic [15:0] d; } word_t;
    word_t       got[$];
    int          pulses[$];
    int          frun = 0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d;
    logic [CHW-1:0] hold_c;
    always @(negedge mclk1) begin
        if (out_valid && out_ready) got.push_back('{ch: out_chan, d: out_data});
        if (hold_v && out_valid) begin
            chk("hold_data", 32'(out_data), 32'(hold_d));
            chk("hold_chan", 32'(out_chan), 32'(hold_c));
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_c = out_chan;
        if (filt_reset) frun++;
        else if (frun != 0) begin pulses.push_back(frun); frun = 0; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mclk1);
        #2;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m, input logic c);
        chan_mask = m; continuous = c; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < SCAN_BUDGET) begin tick(1); n++; end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < SCAN_BUDGET) begin tick(1); n++; end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Expected single scan: one word per set mask bit, ascending, each preceded by a full reset pulse.
    task automatic run_single(input string tag, input logic [NCH-1:0] m, input logic [15:0] base);
        word_t exp_q[$];
        for (int ch = 0; ch < NCH; ch++)
            if (m[ch]) exp_q.push_back('{ch: CHW'(ch), d: base + 16'(ch)});
        fbase = base; out_ready = 1'b1;
        got.delete(); pulses.delete();
        pulse_start(m, 1'b0);
        wait_idle(tag);
        tick(2);
        chk({tag, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
        chk({tag, "_npulses"}, 32'(pulses.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({tag, "_chan"}, 32'(got[i].ch), 32'(exp_q[i].ch));
            chk({tag, "_data"}, 32'(got[i].d), 32'(exp_q[i].d));
        end
        for (int i = 0; i < pulses.size(); i++) chk({tag, "_rstlen"}, 32'(pulses[i]), RST_CYCLES);
        chk({tag, "_valid_end"}, 32'(out_valid), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_chan_sel"}, 32'(chan_sel), 32'd0);
        chk({tag, "_filt_reset"}, 32'(filt_reset), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_chan"}, 32'(out_chan), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        logic [15:0] first_d;
        int n;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        chan_mask = '0; out_ready = 1'b1; wc_hold = 1'b0; fbase = 16'h1000;
        filt_data = '0; word_clk = 1'b0;
        tick(3);
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick(2);
        chk_all_zero("post_reset");

        run_single("scan0101", 4'b0101, 16'h1000);

        for (int k = 0; k < 3; k++)
            run_single("scan_rand", NCH'($urandom_range(1, 15)), 16'($urandom_range(16'h1000, 16'h7000)));

        // Continuous single channel
        fbase = 16'($urandom_range(16'h1000, 16'h7000));
        got.delete(); pulses.delete(); out_ready = 1'b1;
        pulse_start(4'b1000, 1'b1);
        n = 0;
        while (got.size() < 3 && n < 4 * SCAN_BUDGET) begin tick(1); n++; end
        chk("cont_nwords", 32'(got.size() >= 3), 32'd1);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("cont_stop_busy", 32'(busy), 32'd0);
        chk("cont_stop_frst", 32'(filt_reset), 32'd0);
        chk("cont_stop_chan", 32'(chan_sel), 32'd3);
        for (int i = 0; i < got.size(); i++) begin
            chk("cont_chan", 32'(got[i].ch), 32'd3);
            chk("cont_data", 32'(got[i].d), 32'(fbase + 16'd3));
        end
        chk("cont_npulses", 32'(pulses.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < pulses.size(); i++) chk("cont_rstlen", 32'(pulses[i]), RST_CYCLES);
        tick(4);

        // Overrun with out_ready held low
        fbase = 16'($urandom_range(16'h1000, 16'h7000));
        out_ready = 1'b0;
        pulse_start(4'b1111, 1'b0);
        wait_valid("ovr");
        chk("ovr_first_chan", 32'(out_chan), 32'd0);
        chk("ovr_first_data", 32'(out_data), 32'(fbase));
        first_d = out_data;
        chk("ovr_not_yet", 32'(overrun), 32'd0);
        n = 0;
        while (!overrun && n < SCAN_BUDGET) begin tick(1); n++; end
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_data_kept", 32'(out_data), 32'(first_d));
        chk("ovr_chan_kept", 32'(out_chan), 32'd0);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("ovr_stop_busy", 32'(busy), 32'd0);
        chk("ovr_stop_keep_valid", 32'(out_valid), 32'd1);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        pulse_start(4'b0010, 1'b0);
        chk("ovr_clr_by_start", 32'(overrun), 32'd0);
        got.delete();
        out_ready = 1'b1;
        wait_idle("ovr_drain");
        tick(2);
        chk("ovr_drain_n", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("ovr_drain_c0", 32'(got[0].ch), 32'd0);
            chk("ovr_drain_d0", 32'(got[0].d), 32'(fbase));
            chk("ovr_drain_c1", 32'(got[1].ch), 32'd1);
            chk("ovr_drain_d1", 32'(got[1].d), 32'(fbase + 16'd1));
        end

        // Ignored starts
        pulse_start(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("mask0_busy", 32'(busy), 32'd0);
            chk("mask0_frst", 32'(filt_reset), 32'd0);
            tick(1);
        end
        chan_mask = 4'b0001; start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("stopwins_busy", 32'(busy), 32'd0);
        chk("stopwins_frst", 32'(filt_reset), 32'd0);
        fbase = 16'($urandom_range(16'h1000, 16'h7000));
        got.delete(); pulses.delete();
        pulse_start(4'b0010, 1'b0);
        tick(20);
        chan_mask = 4'b1111; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busystart_frst", 32'(filt_reset), 32'd0);
        chk("busystart_chan", 32'(chan_sel), 32'd1);
        wait_idle("busystart");
        tick(2);
        chk("busystart_nwords", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("busystart_word", 32'(got[0].ch), 32'd1);
        chk("busystart_npulses", 32'(pulses.size()), 32'd1);

        // Asynchronous reset while settling with a word pending
        out_ready = 1'b0;
        pulse_start(4'b0011, 1'b0);
        wait_valid("rst");
        n = 0;
        while (!filt_reset && n < 100) begin tick(1); n++; end
        while (filt_reset && n < 200) begin tick(1); n++; end
        tick(50);
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        chk("rst_pre_chan", 32'(chan_sel), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick(2);
        reset_n = 1'b1;
        tick(1);
        run_single("after_rst", 4'b0100, 16'($urandom_range(16'h1000, 16'h7000)));

`ifdef SINC3_SEQ_TIMEOUT_EN
        wc_hold = 1'b1;
        pulse_start(4'b0001, 1'b0);
        n = 0;
        while (filt_reset && n < 100) begin @(negedge mclk1); n++; end
        n = 0;
        while (busy && n < 2 * TIMEOUT) begin @(negedge mclk1); n++; end
        chk("tmo_cycles", 32'(n), TIMEOUT);
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        wc_hold = 1'b0;
        tick(1);
        pulse_start(4'b0001, 1'b0);
        chk("tmo_clr", 32'(timeout_err), 32'd0);
        stop = 1'b1; tick(1); stop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sinc3_seq.md
Name: sinc3_seq

Overview:
- Sequencer for one shared sinc3 decimation filter (24-bit accumulators, decimate-by-256, 16-bit DATA) fed from NCH sigma-delta modulator channels through an external bit mux.
- For each enabled channel it:
  - selects the channel at the mux;
  - pulses the filter reset;
  - discards the settling words;
  - captures one valid 16-bit word;
  - presents that word on a valid/ready output port.
- Supports single-scan and continuous-scan modes.

Parameters:
- NCH, 4, number of modulator channels.
- CHW, 2, width of channel index, equal to clog2(NCH).
- SETTLE_WORDS, 2, word_clk rising edges discarded after a filter reset. The sinc3 needs 3 words to settle, so the 3rd edge is the first kept word.
- RST_CYCLES, 4, mclk1 cycles filt_reset is held high per channel switch.
- TIMEOUT, 1024, mclk1 cycles allowed between word_clk edges. Used only with the optional feature.

Ports:
- mclk1  in  1  modulator clock; the only clock in the block, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a scan. Sampled only in IDLE.
- stop  in  1  abort request, level or pulse, honoured in any state.
- continuous  in  1  when 1, the scan wraps around indefinitely. Latched at start.
- chan_mask  in  NCH  channel enables. Latched at start.
- word_clk  in  1  word clock from the filter, in the mclk1 domain.
- filt_data  in  16  filter DATA output.
- chan_sel  out  CHW  modulator mux select.
- filt_reset  out  1  active-high reset to the filter.
- out_data  out  16  captured word.
- out_chan  out  CHW  channel index of out_data.
- out_valid  out  1  out_data/out_chan are valid.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  sticky; a word was dropped.
- timeout_err  out  1  sticky; exists only under SINC3_SEQ_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0, state IDLE, latched mask and mode 0.
- Edge detect: wc_q is word_clk registered on mclk1. wc_edge = word_clk & ~wc_q. filt_data is stable in the cycle wc_edge is high, so it is sampled in that cycle.
- IDLE:
  - start with a nonzero chan_mask: latch mask and continuous, set chan_sel to the lowest set bit, clear overrun, go to FLUSH.
  - start with mask == 0 is ignored.
  - start in any non-IDLE state is ignored.
- FLUSH:
  - filt_reset = 1 for exactly RST_CYCLES cycles.
  - Clear the settle counter, then go to SETTLE.
  - filt_reset is registered and is low in every other state.
- SETTLE:
  - Each wc_edge increments the settle counter.
  - When the counter reaches SETTLE_WORDS, go to CAPTURE.
  - If SETTLE_WORDS = 0, go to CAPTURE directly.
- CAPTURE, on wc_edge:
  - If out_valid = 0, or out_valid = 1 with out_ready = 1 in the same cycle: load out_data = filt_data and out_chan = chan_sel, and set out_valid = 1.
  - Otherwise drop the word and set overrun = 1.
  - In both cases go to NEXT.
- NEXT (one cycle):
  - Search for the next set mask bit above chan_sel.
  - If one is found: set chan_sel to it and go to FLUSH.
  - If the search wraps: with continuous = 1, go to the lowest set bit and FLUSH; with continuous = 0, go to IDLE.
  - A single-bit mask in continuous mode re-flushes the same channel.
- Output handshake:
  - out_valid clears on the cycle after out_valid & out_ready, unless a new word loads in the same cycle.
  - out_data and out_chan hold stable while out_valid = 1 and out_ready = 0.
- stop:
  - From any state, go to IDLE on the next edge.
  - filt_reset goes to 0; chan_sel holds.
  - A pending out_valid word is retained.
  - stop and start in the same IDLE cycle: stop wins and start is ignored.
- reset_n low mid-scan: everything returns to reset values immediately, including any pending word.
- Latency from start to the first out_valid is approximately:
  - 1 cycle, then RST_CYCLES;
  - then (SETTLE_WORDS+1) word periods of 256 mclk1 cycles each. The first word edge comes 128 cycles after filt_reset falls.

Optional Feature:
- Macro SINC3_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts mclk1 cycles in SETTLE and CAPTURE. It is cleared on each wc_edge and on entry to those states.
  - On reaching TIMEOUT: set timeout_err (sticky, cleared by the next accepted start) and go to IDLE.
- Undefined: no counter and no timeout_err port; SETTLE and CAPTURE wait indefinitely.

Test Plan:
- Mask 4'b0101, continuous = 0, out_ready = 1, bench filter model emitting filt_data = 16'h1000 + channel:
  - exactly 2 words, out_chan 0 then 2, data 16'h1000 then 16'h1002;
  - filt_reset pulse of 4 cycles before each;
  - 3rd word edge after each reset captured;
  - busy falls after the second word.
- Mask 4'b1000, continuous = 1, out_ready = 1:
  - repeated words all on out_chan 3;
  - filt_reset pulses between words;
  - continues until stop, after which busy = 0 within 1 cycle.
- Mask 4'b1111, out_ready held 0:
  - first word (chan 0) held stable;
  - overrun = 1 at the chan 1 capture; out_data unchanged;
  - overrun cleared by the next start.
- start with mask 0, and start while busy: no state change; filt_reset stays 0.
- reset_n asserted during SETTLE with out_valid = 1: all outputs 0 immediately; the next start works normally.
- With SINC3_SEQ_TIMEOUT_EN and TIMEOUT = 1024, word_clk held low: timeout_err = 1 and state IDLE 1024 cycles after entering SETTLE.
